// File: rtl/instr_mem_loader.sv
// Byte-addressed instruction memory with a header + byte-stream download port and a
// combinational big-endian fetch port. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int ADDRESS = 8,
  parameter int INST    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [7:0]         i_byte,
  input  logic               i_byte_valid,
  output logic               o_byte_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [ADDRESS-2:0] o_word_count,
  input  logic [ADDRESS-1:0] addr,
  output logic [INST-1:0]    instr
);

  localparam int DEPTH = 2**ADDRESS;
  localparam logic [ADDRESS:0] CAP_V = (ADDRESS+1)'(1) << (ADDRESS-2);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;
  localparam state_t POST_DATA = CSUM;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;
  localparam state_t POST_DATA = DONE;
`endif

  state_t             state_q, state_d;
  logic [ADDRESS-1:0] wr_q, wr_d;
  logic [ADDRESS:0]   rem_q, rem_d;
  logic [ADDRESS-2:0] n_q, n_d;
  logic [ADDRESS-2:0] wc_q, wc_d;
  logic               we;
  logic [ADDRESS:0]   hdr_n;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         acc_q, acc_d;
`endif

  // Storage is deliberately outside the reset domain: a reset keeps partial loads.
  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  assign hdr_n = (ADDRESS+1)'(i_byte);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rem_q   <= '0;
      n_q     <= '0;
      wc_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rem_q   <= rem_d;
      n_q     <= n_d;
      wc_q    <= wc_d;
`ifdef LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rem_d   = rem_q;
    n_d     = n_q;
    wc_d    = wc_q;
    we      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (i_start) begin
          state_d = HDR;
          wr_d    = '0;
`ifdef LOADER_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end
      HDR: begin
        if (i_byte_valid) begin
          if (hdr_n > CAP_V) begin
            state_d = ERR;
          end else begin
            n_d     = hdr_n[ADDRESS-2:0];
            rem_d   = {hdr_n[ADDRESS-2:0], 2'b00};
            state_d = (hdr_n == '0) ? POST_DATA : DATA;
          end
        end
      end
      DATA: begin
        if (i_byte_valid) begin
          we    = 1'b1;
          wr_d  = wr_q + ADDRESS'(1);
          rem_d = rem_q - (ADDRESS+1)'(1);
`ifdef LOADER_CHECKSUM_EN
          acc_d = acc_q ^ i_byte;
`endif
          if (rem_q == (ADDRESS+1)'(1)) state_d = POST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (i_byte_valid) state_d = (i_byte == acc_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
    // Word count only moves on a successful finish; an aborted session leaves it alone.
    if (state_d == DONE && state_q != DONE) wc_d = n_d;
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_q] <= i_byte;
  end

  assign o_byte_ready = (state_q == HDR) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
                     || (state_q == CSUM)
`endif
                     ;
  assign o_busy       = o_byte_ready;
  assign o_done       = (state_q == DONE);
  assign o_error      = (state_q == ERR);
  assign o_word_count = wc_q;

  assign instr = {mem[addr], mem[addr + ADDRESS'(1)],
                  mem[addr + ADDRESS'(2)], mem[addr + ADDRESS'(3)]};

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; covers the checksum variant when
// LOADER_CHECKSUM_EN is defined for the build.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready, o_busy, o_done, o_error;
  logic [6:0]  o_word_count;
  logic [7:0]  addr;
  logic [31:0] instr;

  int n_chk  = 0;
  int n_fail = 0;

  instr_mem_loader #(.ADDRESS(8), .INST(32)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_byte(i_byte),
    .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_word_count(o_word_count),
    .addr(addr), .instr(instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    i_byte = b; i_byte_valid = 1'b1;
    @(posedge clk); #1;
    i_byte_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    addr = a; #1;
    chk(tag, instr, exp);
  endtask

  task automatic status(input string tag, input logic rdy, input logic dn,
                        input logic er, input logic [6:0] wc);
    chk({tag, ".ready"}, {31'b0, o_byte_ready}, {31'b0, rdy});
    chk({tag, ".busy"},  {31'b0, o_busy},       {31'b0, rdy});
    chk({tag, ".done"},  {31'b0, o_done},       {31'b0, dn});
    chk({tag, ".error"}, {31'b0, o_error},      {31'b0, er});
    chk({tag, ".wc"},    {25'b0, o_word_count}, {25'b0, wc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_start = 1'b0; i_byte = 8'h00; i_byte_valid = 1'b0; addr = 8'h00;
    #23;
    status("reset", 1'b0, 1'b0, 1'b0, 7'd0);
    rd("reset.mem0", 8'h00, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Two-word load, back-to-back bytes
    start();
    status("t1.hdr", 1'b1, 1'b0, 1'b0, 7'd0);
    send(8'h02);
    for (int i = 1; i <= 8; i++) send(8'(i * 8'h11));
`ifdef LOADER_CHECKSUM_EN
    chk("t1.csum_ready", {31'b0, o_byte_ready}, 32'd1);
    send(8'h88);
`endif
    status("t1.end", 1'b0, 1'b1, 1'b0, 7'd2);
    rd("t1.w0", 8'h00, 32'h11223344);
    rd("t1.w1", 8'h04, 32'h55667788);

    // Over-capacity header aborts; memory and word count untouched
    start();
    send(8'h41);
    status("t2.err", 1'b0, 1'b0, 1'b1, 7'd2);
    rd("t2.w0", 8'h00, 32'h11223344);

    // Full-capacity load, byte i = i
    start();
    send(8'h40);
    for (int i = 0; i < 256; i++) send(8'(i));
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    status("t3.full", 1'b0, 1'b1, 1'b0, 7'd64);
    rd("t3.last", 8'hFC, 32'hFCFDFEFF);
    rd("t3.wrap", 8'hFE, 32'hFEFF0001);

    // i_start during DATA is ignored
    start();
    send(8'h01);
    send(8'hAA);
    i_start = 1'b1;
    send(8'hBB);
    i_start = 1'b0;
    chk("t4.still_busy", {31'b0, o_busy}, 32'd1);
    send(8'hCC);
    send(8'hDD);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    status("t4.end", 1'b0, 1'b1, 1'b0, 7'd1);
    rd("t4.w0", 8'h00, 32'hAABBCCDD);

    // Zero-length header
    start();
    send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    chk("t5.csum_ready", {31'b0, o_byte_ready}, 32'd1);
    send(8'h00);
`endif
    status("t5.zero", 1'b0, 1'b1, 1'b0, 7'd0);

`ifdef LOADER_CHECKSUM_EN
    start(); send(8'h01);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    send(8'h0F);
    status("t6.csum_ok", 1'b0, 1'b1, 1'b0, 7'd1);
    start(); send(8'h01);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    send(8'h0E);
    status("t6.csum_bad", 1'b0, 1'b0, 1'b1, 7'd1);
    rd("t6.w0", 8'h00, 32'h01020408);
`endif

    // Reset mid-session with a gap between bytes
    start();
    send(8'h01);
    send(8'hDE);
    @(posedge clk); #1;
    chk("t7.gap_busy", {31'b0, o_busy}, 32'd1);
    send(8'hAD);
    #2 reset = 1'b1;
    #1;
    status("t7.rst", 1'b0, 1'b0, 1'b0, 7'd0);
    addr = 8'h00; #1;
    chk("t7.kept", {16'b0, instr[31:16]}, 32'h0000DEAD);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fresh session after reset starts at address 0 with a clean accumulator
    start();
    send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
`ifdef LOADER_CHECKSUM_EN
    send(8'h08);
`endif
    status("t8.end", 1'b0, 1'b1, 1'b0, 7'd1);
    rd("t8.w0", 8'h00, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
